// File: rtl/wisc_pkg.sv
// Shared MEM-stage types and constants.
// State encoding for the memory FSM plus architectural widths.
package wisc_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      WAIT = 1'b1
   } mem_state_t;

   localparam logic [3:0] REG_SP = 4'hF;
   localparam int         WORD_W = 16;

endpackage

// File: rtl/mem_wait_timer.sv
// Counts WAIT cycles for an outstanding access; expire is combinational on the count, 0 cycles latency.
// No backpressure: clr has priority over en, and the count never runs long enough to wrap.
module mem_wait_timer #(
   parameter int MEM_TIMEOUT = 15
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic expire
);

   logic [7:0] count_q;
   logic [7:0] count_d;

   always_comb begin
      count_d = count_q;
      if (clr) begin
         count_d = 8'd0;
      end else if (en) begin
         count_d = count_q + 8'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         count_q <= 8'd0;
      end else begin
         count_q <= count_d;
      end
   end

   assign expire = (count_q == 8'(MEM_TIMEOUT - 1));

endmodule

// File: rtl/mem_stage_unit.sv
// MEM stage: non-memory ops pass to MEM/WB in 1 cycle; loads/stores hold a req until mem_rdy or timeout.
// stall_out is raised combinationally from acceptance of a memory op until the cycle it completes.
module mem_stage_unit
   import wisc_pkg::*;
#(
   parameter int DATA_W      = WORD_W,
   parameter int MEM_TIMEOUT = 15
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              valid_in,
   input  logic              RegWrite_in,
   input  logic              MemWrite_in,
   input  logic              MemRead_in,
   input  logic              mem_to_reg_in,
   input  logic              call_in,
   input  logic              ret_future_in,
   input  logic [3:0]        reg_rd_in,
   input  logic [DATA_W-1:0] alu_result_in,
   input  logic [DATA_W-1:0] sw_data_in,
   input  logic              HALT_in,
   output logic [DATA_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              mem_re,
   output logic              mem_we,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_rdy,
   output logic              stall_out,
   output logic              valid_out,
   output logic              RegWrite_out,
   output logic              mem_to_reg_out,
   output logic              call_out,
   output logic              ret_future_out,
   output logic              HALT_out,
   output logic [3:0]        reg_rd_out,
   output logic [DATA_W-1:0] wb_data,
   output logic              mem_err
);

   mem_state_t        state_q, state_d;
   logic              halted_q, halted_d;
   logic [DATA_W-1:0] mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
   logic              mem_re_q, mem_re_d;
   logic              mem_we_q, mem_we_d;
   logic              valid_q, valid_d;
   logic              regwrite_q, regwrite_d;
   logic              mem_to_reg_q, mem_to_reg_d;
   logic              call_q, call_d;
   logic              ret_q, ret_d;
   logic              halt_q, halt_d;
   logic [3:0]        reg_rd_q, reg_rd_d;
   logic [DATA_W-1:0] wb_data_q, wb_data_d;
   logic              mem_err_q, mem_err_d;

   // Fields of the access in flight, held here so MEM/WB outputs stay untouched until completion.
   logic              p_regwrite_q, p_regwrite_d;
   logic              p_mem_to_reg_q, p_mem_to_reg_d;
   logic              p_call_q, p_call_d;
   logic              p_ret_q, p_ret_d;
   logic              p_halt_q, p_halt_d;
   logic              p_load_q, p_load_d;
   logic [3:0]        p_rd_q, p_rd_d;
   logic [DATA_W-1:0] p_alu_q, p_alu_d;

   logic accept, is_mem, timer_clr, timer_en, timer_expire;

   assign accept = valid_in & ~halted_q;
   assign is_mem = MemRead_in | MemWrite_in;

   assign stall_out = ((state_q == IDLE) & accept & is_mem) |
                      ((state_q == WAIT) & ~mem_rdy & ~timer_expire);

   mem_wait_timer #(
      .MEM_TIMEOUT(MEM_TIMEOUT)
   ) u_timer (
      .clk   (clk),
      .rst   (rst),
      .clr   (timer_clr),
      .en    (timer_en),
      .expire(timer_expire)
   );

   always_comb begin
      state_d        = state_q;
      halted_d       = halted_q;
      mem_addr_d     = mem_addr_q;
      mem_wdata_d    = mem_wdata_q;
      mem_re_d       = mem_re_q;
      mem_we_d       = mem_we_q;
      valid_d        = valid_q;
      regwrite_d     = regwrite_q;
      mem_to_reg_d   = mem_to_reg_q;
      call_d         = call_q;
      ret_d          = ret_q;
      halt_d         = halt_q;
      reg_rd_d       = reg_rd_q;
      wb_data_d      = wb_data_q;
      mem_err_d      = mem_err_q;
      p_regwrite_d   = p_regwrite_q;
      p_mem_to_reg_d = p_mem_to_reg_q;
      p_call_d       = p_call_q;
      p_ret_d        = p_ret_q;
      p_halt_d       = p_halt_q;
      p_load_d       = p_load_q;
      p_rd_d         = p_rd_q;
      p_alu_d        = p_alu_q;
      timer_clr      = 1'b0;
      timer_en       = 1'b0;

      case (state_q)
         IDLE: begin
            if (!accept) begin
               valid_d = 1'b0;
            end else if (!is_mem) begin
               valid_d      = 1'b1;
               regwrite_d   = RegWrite_in;
               mem_to_reg_d = mem_to_reg_in;
               call_d       = call_in;
               ret_d        = ret_future_in;
               halt_d       = HALT_in;
               reg_rd_d     = reg_rd_in;
               wb_data_d    = alu_result_in;
               halted_d     = HALT_in;
            end else begin
               valid_d        = 1'b0;
               p_regwrite_d   = RegWrite_in;
               p_mem_to_reg_d = mem_to_reg_in;
               p_call_d       = call_in;
               p_ret_d        = ret_future_in;
               p_halt_d       = HALT_in;
               p_rd_d         = reg_rd_in;
               p_alu_d        = alu_result_in;
               // A simultaneous read+write is treated as a store only.
               p_load_d       = MemRead_in & ~MemWrite_in;
               mem_re_d       = MemRead_in & ~MemWrite_in;
               mem_we_d       = MemWrite_in;
               mem_addr_d     = alu_result_in;
               mem_wdata_d    = sw_data_in;
               timer_clr      = 1'b1;
               state_d        = WAIT;
            end
         end
         WAIT: begin
            if (mem_rdy || timer_expire) begin
               mem_re_d     = 1'b0;
               mem_we_d     = 1'b0;
               valid_d      = 1'b1;
               mem_to_reg_d = p_mem_to_reg_q;
               call_d       = p_call_q;
               ret_d        = p_ret_q;
               halt_d       = p_halt_q;
               reg_rd_d     = p_rd_q;
               halted_d     = halted_q | p_halt_q;
               state_d      = IDLE;
               // mem_rdy wins over an expiry landing in the same cycle.
               if (mem_rdy) begin
                  regwrite_d = p_regwrite_q;
                  wb_data_d  = p_load_q ? mem_rdata : p_alu_q;
               end else begin
                  regwrite_d = 1'b0;
                  wb_data_d  = '0;
                  mem_err_d  = 1'b1;
               end
            end else begin
               timer_en = 1'b1;
               valid_d  = 1'b0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= IDLE;
         halted_q       <= 1'b0;
         mem_addr_q     <= '0;
         mem_wdata_q    <= '0;
         mem_re_q       <= 1'b0;
         mem_we_q       <= 1'b0;
         valid_q        <= 1'b0;
         regwrite_q     <= 1'b0;
         mem_to_reg_q   <= 1'b0;
         call_q         <= 1'b0;
         ret_q          <= 1'b0;
         halt_q         <= 1'b0;
         reg_rd_q       <= 4'd0;
         wb_data_q      <= '0;
         mem_err_q      <= 1'b0;
         p_regwrite_q   <= 1'b0;
         p_mem_to_reg_q <= 1'b0;
         p_call_q       <= 1'b0;
         p_ret_q        <= 1'b0;
         p_halt_q       <= 1'b0;
         p_load_q       <= 1'b0;
         p_rd_q         <= 4'd0;
         p_alu_q        <= '0;
      end else begin
         state_q        <= state_d;
         halted_q       <= halted_d;
         mem_addr_q     <= mem_addr_d;
         mem_wdata_q    <= mem_wdata_d;
         mem_re_q       <= mem_re_d;
         mem_we_q       <= mem_we_d;
         valid_q        <= valid_d;
         regwrite_q     <= regwrite_d;
         mem_to_reg_q   <= mem_to_reg_d;
         call_q         <= call_d;
         ret_q          <= ret_d;
         halt_q         <= halt_d;
         reg_rd_q       <= reg_rd_d;
         wb_data_q      <= wb_data_d;
         mem_err_q      <= mem_err_d;
         p_regwrite_q   <= p_regwrite_d;
         p_mem_to_reg_q <= p_mem_to_reg_d;
         p_call_q       <= p_call_d;
         p_ret_q        <= p_ret_d;
         p_halt_q       <= p_halt_d;
         p_load_q       <= p_load_d;
         p_rd_q         <= p_rd_d;
         p_alu_q        <= p_alu_d;
      end
   end

   assign mem_addr       = mem_addr_q;
   assign mem_wdata      = mem_wdata_q;
   assign mem_re         = mem_re_q;
   assign mem_we         = mem_we_q;
   assign valid_out      = valid_q;
   assign RegWrite_out   = regwrite_q;
   assign mem_to_reg_out = mem_to_reg_q;
   assign call_out       = call_q;
   assign ret_future_out = ret_q;
   assign HALT_out       = halt_q;
   assign reg_rd_out     = reg_rd_q;
   assign wb_data        = wb_data_q;
   assign mem_err        = mem_err_q;

endmodule

// File: tb/tb_mem_stage_unit.sv
// Directed-vector bench for mem_stage_unit; inputs change and outputs are sampled on the falling edge.
module tb_mem_stage_unit;
   import wisc_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        valid_in, RegWrite_in, MemWrite_in, MemRead_in, mem_to_reg_in;
   logic        call_in, ret_future_in, HALT_in, mem_rdy;
   logic [3:0]  reg_rd_in;
   logic [15:0] alu_result_in, sw_data_in, mem_rdata;
   logic [15:0] mem_addr, mem_wdata, wb_data;
   logic        mem_re, mem_we, stall_out, valid_out, RegWrite_out, mem_to_reg_out;
   logic        call_out, ret_future_out, HALT_out, mem_err;
   logic [3:0]  reg_rd_out;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   mem_stage_unit #(.DATA_W(16), .MEM_TIMEOUT(15)) dut (
      .clk(clk), .rst(rst), .valid_in(valid_in), .RegWrite_in(RegWrite_in),
      .MemWrite_in(MemWrite_in), .MemRead_in(MemRead_in), .mem_to_reg_in(mem_to_reg_in),
      .call_in(call_in), .ret_future_in(ret_future_in), .reg_rd_in(reg_rd_in),
      .alu_result_in(alu_result_in), .sw_data_in(sw_data_in), .HALT_in(HALT_in),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_re(mem_re), .mem_we(mem_we),
      .mem_rdata(mem_rdata), .mem_rdy(mem_rdy), .stall_out(stall_out),
      .valid_out(valid_out), .RegWrite_out(RegWrite_out), .mem_to_reg_out(mem_to_reg_out),
      .call_out(call_out), .ret_future_out(ret_future_out), .HALT_out(HALT_out),
      .reg_rd_out(reg_rd_out), .wb_data(wb_data), .mem_err(mem_err)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask

   task automatic idle_in();
      valid_in = 0; RegWrite_in = 0; MemWrite_in = 0; MemRead_in = 0;
      mem_to_reg_in = 0; call_in = 0; ret_future_in = 0; HALT_in = 0;
      reg_rd_in = 4'd0; alu_result_in = 16'h0; sw_data_in = 16'h0;
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int re_cnt;
      bit done;
      idle_in();
      mem_rdy = 0; mem_rdata = 16'h0;
      rst = 1;
      tick(); tick();
      rst = 0;
      tick();
      chk("rst_valid", valid_out, 0);
      chk("rst_re", mem_re, 0);
      chk("rst_we", mem_we, 0);
      chk("rst_err", mem_err, 0);
      chk("rst_wb", wb_data, 0);
      chk("rst_stall", stall_out, 0);

      // ADD pass-through
      valid_in = 1; RegWrite_in = 1; reg_rd_in = 4'd3; alu_result_in = 16'h1234;
      #1 chk("add_stall", stall_out, 0);
      tick(); idle_in();
      chk("add_valid", valid_out, 1);
      chk("add_wb", wb_data, 16'h1234);
      chk("add_rd", reg_rd_out, 3);
      chk("add_rw", RegWrite_out, 1);
      tick();
      chk("bubble_valid", valid_out, 0);
      chk("bubble_keep_wb", wb_data, 16'h1234);

      // mem_rdy while IDLE does nothing
      mem_rdy = 1; mem_rdata = 16'h7777;
      tick(); mem_rdy = 0;
      chk("idle_rdy_valid", valid_out, 0);
      chk("idle_rdy_wb", wb_data, 16'h1234);

      // Load completing on the third WAIT cycle
      valid_in = 1; MemRead_in = 1; mem_to_reg_in = 1; RegWrite_in = 1;
      reg_rd_in = 4'd5; alu_result_in = 16'h0040;
      #1 chk("ld_stall_idle", stall_out, 1);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("ld_re", mem_re, 1);
         chk("ld_addr", mem_addr, 16'h0040);
         chk("ld_valid0", valid_out, 0);
         if (i == 2) begin
            mem_rdy = 1; mem_rdata = 16'hBEEF;
            #1 chk("ld_stall_rdy", stall_out, 0);
         end else begin
            #1 chk("ld_stall_wait", stall_out, 1);
         end
      end
      tick(); idle_in(); mem_rdy = 0;
      chk("ld_valid", valid_out, 1);
      chk("ld_wb", wb_data, 16'hBEEF);
      chk("ld_re_drop", mem_re, 0);
      chk("ld_rd", reg_rd_out, 5);
      chk("ld_m2r", mem_to_reg_out, 1);

      // Call push
      tick();
      valid_in = 1; MemWrite_in = 1; call_in = 1; reg_rd_in = REG_SP;
      alu_result_in = 16'hFFFE; sw_data_in = 16'h0102;
      tick();
      chk("call_we", mem_we, 1);
      chk("call_re", mem_re, 0);
      chk("call_wdata", mem_wdata, 16'h0102);
      chk("call_addr", mem_addr, 16'hFFFE);
      mem_rdy = 1;
      tick(); idle_in(); mem_rdy = 0;
      chk("call_we_drop", mem_we, 0);
      chk("call_valid", valid_out, 1);
      chk("call_out", call_out, 1);
      chk("call_rd", reg_rd_out, 4'hF);
      chk("call_wb", wb_data, 16'hFFFE);

      // Read and write together behaves as a store
      tick();
      valid_in = 1; MemRead_in = 1; MemWrite_in = 1;
      alu_result_in = 16'h0200; sw_data_in = 16'h0A0A;
      tick();
      chk("rw_re", mem_re, 0);
      chk("rw_we", mem_we, 1);
      mem_rdy = 1;
      tick(); idle_in(); mem_rdy = 0;
      chk("rw_wb", wb_data, 16'h0200);

      // Timeout on a load
      tick();
      valid_in = 1; MemRead_in = 1; mem_to_reg_in = 1; RegWrite_in = 1;
      reg_rd_in = 4'd6; alu_result_in = 16'h0080;
      re_cnt = 0; done = 0;
      for (int i = 0; i < 40 && !done; i++) begin
         tick();
         if (valid_out) done = 1;
         else if (mem_re) re_cnt++;
      end
      idle_in();
      chk("to_done", done, 1);
      chk("to_wait_cycles", re_cnt, 15);
      chk("to_err", mem_err, 1);
      chk("to_rw", RegWrite_out, 0);
      chk("to_wb", wb_data, 0);
      chk("to_re_drop", mem_re, 0);
      tick();
      chk("to_err_sticky", mem_err, 1);

      // HALT then ADD
      valid_in = 1; HALT_in = 1;
      tick(); idle_in();
      chk("halt_valid", valid_out, 1);
      chk("halt_out", HALT_out, 1);
      valid_in = 1; RegWrite_in = 1; alu_result_in = 16'h5555;
      #1 chk("halted_stall", stall_out, 0);
      tick();
      chk("halted_valid", valid_out, 0);
      idle_in(); valid_in = 1; MemRead_in = 1; alu_result_in = 16'h0300;
      #1 chk("halted_ld_stall", stall_out, 0);
      tick(); idle_in();
      chk("halted_ld_re", mem_re, 0);
      chk("halted_valid2", valid_out, 0);

      // Reset clears halted and the sticky error
      rst = 1; tick(); rst = 0;
      chk("rst2_err", mem_err, 0);
      valid_in = 1; RegWrite_in = 1; alu_result_in = 16'h0AAA;
      tick(); idle_in();
      chk("unhalt_valid", valid_out, 1);
      chk("unhalt_wb", wb_data, 16'h0AAA);

      // Reset in the middle of an access
      valid_in = 1; MemRead_in = 1; RegWrite_in = 1; alu_result_in = 16'h0100;
      tick();
      chk("mid_re", mem_re, 1);
      idle_in(); rst = 1;
      tick(); rst = 0;
      chk("mid_re_drop", mem_re, 0);
      chk("mid_valid", valid_out, 0);
      chk("mid_stall", stall_out, 0);
      mem_rdy = 1; mem_rdata = 16'h1111;
      tick(); mem_rdy = 0;
      chk("mid_late_rdy_valid", valid_out, 0);
      chk("mid_late_rdy_wb", wb_data, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
